// File: rtl/y_stream_packer.sv
// Packs the serial detector output y into LSB-first WIDTH-bit words and
// presents each word with its population count on a valid/ready port.
module y_stream_packer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             busy,
  output logic             overflow
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t             state,      state_nx;
  logic [IDX_W-1:0]   idx,        idx_nx;
  logic [WIDTH-1:0]   partial,    partial_nx;
  logic [CNT_W-1:0]   run_cnt,    run_cnt_nx;
  logic [WIDTH-1:0]   word_nx;
  logic [CNT_W-1:0]   ones_nx;
  logic               valid_nx;
  logic               overflow_nx;
  logic               stop_pend,  stop_pend_nx;

  // Partial word and running count as they would look with bit_in accepted.
  logic [WIDTH-1:0]   partial_ins;
  logic [CNT_W-1:0]   cnt_ins;

  // NOTE: every signal assigned in an always_comb gets a default on entry;
  // a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    partial_ins      = partial;
    partial_ins[idx] = bit_in;
    cnt_ins          = run_cnt + CNT_W'(bit_in);

    state_nx     = state;
    idx_nx       = idx;
    partial_nx   = partial;
    run_cnt_nx   = run_cnt;
    word_nx      = word_out;
    ones_nx      = ones_cnt;
    valid_nx     = word_valid;
    overflow_nx  = overflow;
    stop_pend_nx = stop_pend;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx    = COLLECT;
          idx_nx      = '0;
          partial_nx  = '0;
          run_cnt_nx  = '0;
          overflow_nx = 1'b0;
        end
      end

      COLLECT: begin
        if (stop) begin
          state_nx   = IDLE;
          idx_nx     = '0;
          partial_nx = '0;
          run_cnt_nx = '0;
        end else if (start) begin
          // Restart drops the partial word and this cycle's bit.
          idx_nx      = '0;
          partial_nx  = '0;
          run_cnt_nx  = '0;
          overflow_nx = 1'b0;
        end else if (bit_valid) begin
          if (idx == LAST_IDX) begin
            word_nx      = partial_ins;
            ones_nx      = cnt_ins;
            valid_nx     = 1'b1;
            idx_nx       = '0;
            partial_nx   = '0;
            run_cnt_nx   = '0;
            stop_pend_nx = 1'b0;
            state_nx     = HOLD;
          end else begin
            partial_nx = partial_ins;
            run_cnt_nx = cnt_ins;
            idx_nx     = idx + 1'b1;
          end
        end
      end

      HOLD: begin
        if (word_ready) begin
          valid_nx     = 1'b0;
          stop_pend_nx = 1'b0;
          if (stop_pend || stop) begin
            state_nx = IDLE;
          end else begin
            state_nx = COLLECT;
            // Zero-bubble: a bit arriving with the handshake opens the next word.
            if (bit_valid) begin
              partial_nx = {{(WIDTH-1){1'b0}}, bit_in};
              run_cnt_nx = CNT_W'(bit_in);
              idx_nx     = IDX_W'(1);
            end
          end
        end else begin
          if (stop) stop_pend_nx = 1'b1;
          if (bit_valid) overflow_nx = 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      partial    <= '0;
      run_cnt    <= '0;
      word_out   <= '0;
      ones_cnt   <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
      stop_pend  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      partial    <= partial_nx;
      run_cnt    <= run_cnt_nx;
      word_out   <= word_nx;
      ones_cnt   <= ones_nx;
      word_valid <= valid_nx;
      overflow   <= overflow_nx;
      stop_pend  <= stop_pend_nx;
      busy       <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_y_stream_packer.sv
// Directed bench for y_stream_packer: hand-computed words, counts and flags
// across stalls, zero-bubble handoff, stop, gapped input and async reset.
module tb_y_stream_packer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop, bit_valid, bit_in, word_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic [CNT_W-1:0] ones_cnt;
  logic             busy, overflow;

  int checks   = 0;
  int failures = 0;

  y_stream_packer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .ones_cnt   (ones_cnt),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cycle(input logic s_start, input logic s_stop, input logic s_bv,
                       input logic s_bit, input logic s_rdy);
    start      = s_start;
    stop       = s_stop;
    bit_valid  = s_bv;
    bit_in     = s_bit;
    word_ready = s_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) cycle(1'b0, 1'b0, 1'b1, w[i], 1'b0);
  endtask

  task automatic handshake();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic expect_word(input string tag, input logic [WIDTH-1:0] w,
                             input logic [CNT_W-1:0] n);
    check({tag, "_valid"}, 32'(word_valid), 32'd1);
    check({tag, "_word"},  32'(word_out),   32'(w));
    check({tag, "_ones"},  32'(ones_cnt),   32'(n));
  endtask

  task automatic expect_cleared(input string tag);
    check({tag, "_word"},  32'(word_out),   32'd0);
    check({tag, "_ones"},  32'(ones_cnt),   32'd0);
    check({tag, "_valid"}, 32'(word_valid), 32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_ovf"},   32'(overflow),   32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_cleared("reset");
    rst_n = 1'b1;

    // 1: bits 1,0,1,1,0,0,0,1 -> 8'h8D, four ones, valid on the 8th edge.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    send_bits(8'h8D, 0, 6);
    check("t1_not_yet", 32'(word_valid), 32'd0);
    send_bits(8'h8D, 7, 7);
    expect_word("t1", 8'h8D, 4'd4);
    handshake();
    check("t1_released", 32'(word_valid), 32'd0);

    // 2: stall with bits arriving -> held word, sticky overflow.
    send_bits(8'h3C, 0, 7);
    expect_word("t2a", 8'h3C, 4'd4);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_word("t2_held", 8'h3C, 4'd4);
    check("t2_ovf", 32'(overflow), 32'd1);
    handshake();
    send_bits(8'h01, 0, 7);
    expect_word("t2b", 8'h01, 4'd1);
    check("t2_ovf_sticky", 32'(overflow), 32'd1);
    handshake();

    // 3: start clears overflow; zero-bubble handoff into a second word.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    send_bits(8'hA5, 0, 7);
    expect_word("t3a", 8'hA5, 4'd4);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("t3_hs", 32'(word_valid), 32'd0);
    send_bits(8'h5B, 1, 7);
    expect_word("t3b", 8'h5B, 4'd5);
    check("t3_no_ovf", 32'(overflow), 32'd0);
    handshake();

    // 3b: restart mid-word drops the partial and that cycle's bit.
    send_bits(8'hFF, 0, 2);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_bits(8'h12, 0, 7);
    expect_word("t3c", 8'h12, 4'd2);
    handshake();

    // 4: stop after 5 bits -> IDLE with no word; bits in IDLE ignored.
    send_bits(8'hFF, 0, 4);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_valid", 32'(word_valid), 32'd0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t4_idle_ovf", 32'(overflow), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'h3C, 0, 7);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_word("t4_hold_stop", 8'h3C, 4'd4);
    check("t4_hold_busy", 32'(busy), 32'd1);
    handshake();
    check("t4_end_valid", 32'(word_valid), 32'd0);
    check("t4_end_busy", 32'(busy), 32'd0);

    // 5: bits every third cycle, all ones then all zeros.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      if (i == WIDTH - 2) check("t5_gap_wait", 32'(word_valid), 32'd0);
      if (i < WIDTH - 1) repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    expect_word("t5_ones", 8'hFF, 4'd8);
    handshake();
    for (int i = 0; i < WIDTH; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i < WIDTH - 1) repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    expect_word("t5_zeros", 8'h00, 4'd0);
    handshake();

    // 6: async reset during HOLD (with overflow set) and mid-word.
    send_bits(8'hC3, 0, 7);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_word("t6_pre", 8'hC3, 4'd4);
    check("t6_pre_ovf", 32'(overflow), 32'd1);
    #2 rst_n = 1'b0;
    #1 expect_cleared("t6_hold_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'hFF, 0, 3);
    check("t6_mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 expect_cleared("t6_mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'h96, 0, 7);
    expect_word("t6_fresh", 8'h96, 4'd4);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
